// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the CPU datapath and a word-wide data memory.
// Sub-word stores are read-modify-write; loads return aligned, extended data.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Req,
    input  logic              Req_write,
    input  logic [1:0]        Req_size,
    input  logic              Req_signed,
    input  logic [ADDR_W-1:0] Req_addr,
    input  logic [DATA_W-1:0] Req_wdata,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [DATA_W-1:0] Load_data,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_write_data,
    output logic              Mem_write,
    input  logic [DATA_W-1:0] Mem_read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] old_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic              signed_q;

    logic              reject;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_ext;
    logic [DATA_W-1:0] merged;

    always_comb begin
        reject = (Req_size == 2'b11)
              || (Req_size == 2'b01 && Req_addr[0])
              || (Req_size == 2'b10 && Req_addr[1:0] != 2'b00);
    end

    always_comb begin
        rd_byte = Mem_read_data[{addr_q[1:0], 3'b000} +: 8];
        rd_half = addr_q[1] ? Mem_read_data[31:16] : Mem_read_data[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_ext = Mem_read_data;
        endcase
    end

    // Only the addressed lane(s) of the previously read word are replaced.
    always_comb begin
        merged = old_q;
        case (size_q)
            2'b00: merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1])
                    merged[31:16] = wdata_q[15:0];
                else
                    merged[15:0] = wdata_q[15:0];
            end
            default: merged = wdata_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            old_q     <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
            signed_q  <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Err       <= 1'b0;
            Load_data <= '0;
        end else begin
            Err <= 1'b0;
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Req) begin
                        addr_q   <= Req_addr;
                        wdata_q  <= Req_wdata;
                        size_q   <= Req_size;
                        write_q  <= Req_write;
                        signed_q <= Req_signed;
                        Busy     <= 1'b1;
                        if (reject) begin
                            state <= DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end else if (Req_write && Req_size == 2'b10) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    old_q <= Mem_read_data;
                    if (write_q) begin
                        state <= WR;
                    end else begin
                        Load_data <= load_ext;
                        state     <= DONE;
                        Done      <= 1'b1;
                    end
                end
                WR: begin
                    state <= DONE;
                    Done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Write enable is decoded from state so an asynchronous reset kills it at once.
    assign Mem_write      = (state == WR);
    assign Mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    assign Mem_write_data = merged;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses checked against a byte-array reference model.
module tb_mem_access_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req;
    logic        Req_write;
    logic [1:0]  Req_size;
    logic        Req_signed;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [31:0] Load_data;
    logic [31:0] Mem_addr;
    logic [31:0] Mem_write_data;
    logic        Mem_write;
    logic [31:0] Mem_read_data;

    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Req_write(Req_write),
        .Req_size(Req_size), .Req_signed(Req_signed), .Req_addr(Req_addr),
        .Req_wdata(Req_wdata), .Busy(Busy), .Done(Done), .Err(Err),
        .Load_data(Load_data), .Mem_addr(Mem_addr), .Mem_write_data(Mem_write_data),
        .Mem_write(Mem_write), .Mem_read_data(Mem_read_data)
    );

    always #5 Clk = ~Clk;

    // Environment memory: 64 words, plus a poke port for preloading.
    logic [31:0] mem [64];
    logic        poke_en = 1'b0;
    logic [5:0]  poke_idx = '0;
    logic [31:0] poke_data = '0;

    assign Mem_read_data = mem[Mem_addr[7:2]];

    always @(posedge Clk) begin
        if (Mem_write)
            mem[Mem_addr[7:2]] <= Mem_write_data;
        else if (poke_en)
            mem[poke_idx] <= poke_data;
    end

    // Reference model: flat byte array, little-endian.
    logic [7:0]  ref_mem [256];
    logic [31:0] ld_exp = '0;

    function automatic logic [31:0] ref_word(input int unsigned a);
        int unsigned b = a & 32'hFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [31:0] ref_load(input int unsigned a, input int unsigned n, input logic sg);
        logic [31:0] v = '0;
        for (int unsigned i = 0; i < n; i++)
            v = v | (32'(ref_mem[a+i]) << (8*i));
        if (sg && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic poke(input int unsigned a, input logic [31:0] v);
        @(negedge Clk);
        poke_en = 1'b1; poke_idx = 6'(a >> 2); poke_data = v;
        @(posedge Clk);
        #1 poke_en = 1'b0;
        for (int unsigned i = 0; i < 4; i++)
            ref_mem[(a & 32'hFC) + i] = v[8*i +: 8];
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd);
        Req = 1'b1; Req_write = wr; Req_size = sz; Req_signed = sg;
        Req_addr = a; Req_wdata = wd;
    endtask

    task automatic access(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [7:0] a, input logic [31:0] wd);
        int unsigned n, lat_exp, cyc, wr_cycles, wr_at;
        logic rej, done_seen;
        n   = 32'd1 << sz;
        rej = (sz == 2'd3) || ((32'(a) % n) != 0);
        if (rej)            lat_exp = 1;
        else if (!wr)       lat_exp = 2;
        else if (sz == 2'd2) lat_exp = 2;
        else                lat_exp = 3;
        if (!rej && !wr) ld_exp = ref_load(32'(a), n, sg);
        if (!rej && wr)
            for (int unsigned i = 0; i < n; i++)
                ref_mem[32'(a) + i] = wd[8*i +: 8];

        @(negedge Clk);
        check("idle_busy", 32'(Busy), 32'd0);
        drive_req(wr, sz, sg, {24'h0, a}, wd);
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        cyc = 1; wr_cycles = 0; wr_at = 0; done_seen = 1'b0;
        while (!done_seen && cyc <= 8) begin
            check("busy", 32'(Busy), 32'd1);
            if (Mem_write) begin
                wr_cycles++;
                wr_at = cyc;
                check("wr_addr", Mem_addr, {24'h0, a & 8'hFC});
                check("wr_data", Mem_write_data, ref_word(32'(a)));
            end
            if (Done) begin
                done_seen = 1'b1;
                check("err", 32'(Err), 32'(rej));
                check("load_data", Load_data, ld_exp);
            end else begin
                check("err_low", 32'(Err), 32'd0);
                @(negedge Clk);
                cyc++;
            end
        end
        check("latency", done_seen ? cyc : 32'd0, lat_exp);
        check("n_writes", wr_cycles, (!rej && wr) ? 32'd1 : 32'd0);
        if (wr_cycles != 0) check("write_cycle", wr_at, lat_exp - 1);
    endtask

    initial begin
        int unsigned dones;
        logic [31:0] saved;
        Reset_n = 1'b0; Req = 1'b0; Req_write = 1'b0; Req_size = '0;
        Req_signed = 1'b0; Req_addr = '0; Req_wdata = '0;
        repeat (2) @(negedge Clk);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_mwr", 32'(Mem_write), 32'd0);
        check("rst_ld", Load_data, 32'd0);
        check("rst_maddr", Mem_addr, 32'd0);
        check("rst_mwd", Mem_write_data, 32'd0);
        Reset_n = 1'b1;

        for (int unsigned w = 0; w < 64; w++) poke(w * 4, $urandom);

        // Word store then word load
        access(1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF);
        access(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
        check("t1_load", Load_data, 32'hDEADBEEF);

        // Byte store read-modify-write
        poke(32'h10, 32'h11223344);
        access(1'b1, 2'd0, 1'b0, 8'h12, 32'h000000AA);
        check("t2_word", mem[4], 32'h11AA3344);

        // Sign/zero extension
        poke(32'h20, 32'h80F07F01);
        access(1'b0, 2'd0, 1'b1, 8'h22, 32'h0);
        check("t3_sbyte", Load_data, 32'hFFFFFFF0);
        access(1'b0, 2'd1, 1'b0, 8'h22, 32'h0);
        check("t3_uhalf", Load_data, 32'h000080F0);
        access(1'b0, 2'd1, 1'b1, 8'h20, 32'h0);
        check("t3_shalf", Load_data, 32'h00007F01);

        // Misaligned word store
        access(1'b1, 2'd2, 1'b0, 8'h13, 32'h12345678);
        check("t4_mem", mem[4], 32'h11AA3344);

        // Reset while in WR of a byte store
        saved = mem[12];
        @(negedge Clk);
        drive_req(1'b1, 2'd0, 1'b0, 32'h31, 32'h5A);
        @(posedge Clk);
        @(negedge Clk);
        Req = 1'b0;
        @(negedge Clk);
        check("t5_in_wr", 32'(Mem_write), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("t5_mwr", 32'(Mem_write), 32'd0);
        check("t5_busy", 32'(Busy), 32'd0);
        check("t5_done", 32'(Done), 32'd0);
        check("t5_err", 32'(Err), 32'd0);
        check("t5_ld", Load_data, 32'd0);
        check("t5_maddr", Mem_addr, 32'd0);
        check("t5_mwd", Mem_write_data, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        check("t5_mem", mem[12], saved);
        ld_exp = '0;

        // Request pulsed during RD of a load is ignored
        ld_exp = ref_load(32'h40, 4, 1'b0);
        @(negedge Clk);
        drive_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
        @(posedge Clk);
        @(negedge Clk);
        drive_req(1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D);
        @(negedge Clk);
        Req = 1'b0;
        dones = Done ? 1 : 0;
        check("t6_done", 32'(Done), 32'd1);
        check("t6_ld", Load_data, ld_exp);
        for (int i = 0; i < 4; i++) begin
            check("t6_maddr", Mem_addr, 32'h40);
            @(negedge Clk);
            if (Done) dones++;
        end
        check("t6_ndone", dones, 32'd1);
        check("t6_busy", 32'(Busy), 32'd0);

        // Randomized accesses, mostly aligned
        for (int k = 0; k < 150; k++) begin
            logic [1:0] sz;
            logic [7:0] a;
            sz = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
                a = a & ~8'((32'd1 << sz) - 1);
            access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        for (int unsigned w = 0; w < 64; w++)
            check("final_mem", mem[w], ref_word(w * 4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store sequencer that sits between the CPU datapath and the word-wide data memory (`DM`): it accepts one byte, halfword or word access at a time over a req/done handshake and drives the memory's address, write-data and write-enable ports. Sub-word stores are done as read-modify-write, because the memory only writes whole words. Loads return aligned, zero- or sign-extended data. Misaligned or reserved-size requests are rejected without touching memory.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `DATA_W`, default 32: data width. Fixed at 32; byte-lane logic assumes 4 lanes.
- `Clk`  in  1: rising-edge clock.
- `Reset_n`  in  1: asynchronous, active-low reset.
- `Req`  in  1: access request; sampled only in IDLE.
- `Req_write`  in  1: 1 = store, 0 = load.
- `Req_size`  in  2: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- `Req_signed`  in  1: loads only; 1 = sign-extend, 0 = zero-extend.
- `Req_addr`  in  ADDR_W: byte address.
- `Req_wdata`  in  32: store data; the operand sits in the low bits.
- `Busy`  out  1: high whenever state ≠ IDLE.
- `Done`  out  1: one-cycle completion pulse.
- `Err`  out  1: valid with `Done`; 1 = request rejected.
- `Load_data`  out  32: extended load result, registered. Holds its value until the next successful load.
- `Mem_addr`  out  ADDR_W: `{addr_q[ADDR_W-1:2], 2'b00}`.
- `Mem_write_data`  out  32: merged word to store.
- `Mem_write`  out  1: memory write enable; high only in WR.
- `Mem_read_data`  in  32: combinational read port of the memory, addressed by `Mem_addr`.

## Operation
- **Lane mapping (little-endian).**
  - Byte `k = addr[1:0]` occupies bits `[8k+7:8k]`.
  - A halfword with `addr[1]=0` occupies `[15:0]`; with `addr[1]=1` it occupies `[31:16]`.
- **Acceptance.** In IDLE with `Req=1`, latch `addr_q`, `wdata_q`, `size_q`, `write_q` and `signed_q`, then branch:
  - Misaligned or reserved request → DONE with `Err=1`. This covers: half with `addr[0]=1`, word with `addr[1:0]≠0`, or size 11.
  - Load (any size) → RD.
  - Word store → WR.
  - Byte or half store → RD.
- **States:** IDLE, RD, WR, DONE.
  - **RD:** `Mem_write=0`. At the clock edge, `old_q <= Mem_read_data`.
    - For a load, also `Load_data <=` the extracted lane, extended per `signed_q`. Next state is DONE.
    - For a sub-word store, next state is WR.
  - **WR:** `Mem_write=1`. `Mem_write_data` depends on size:
    - Word: `wdata_q`.
    - Byte or half: `old_q` with only the addressed lane(s) replaced by `wdata_q[7:0]` or `wdata_q[15:0]`.
    - Next state is DONE.
  - **DONE:** `Done=1`, `Busy=1`. Next state is IDLE unconditionally.
- **Requests while not in IDLE** (including DONE) are ignored, with no queueing. The requester holds off until it has seen `Done`.
- **Rejected requests** leave `Load_data` and memory untouched, and `Mem_write` is never asserted.
- **`Err`** is registered and is cleared in every state except DONE.

## Timing
- **Reset values:** state=IDLE; `Busy`, `Done`, `Err`, `Mem_write` = 0; `Load_data`, `Mem_addr`, `Mem_write_data`, `old_q` = 0.
- **Reset mid-operation:** asynchronous return to IDLE.
  - `Mem_write` is decoded from state, so it drops immediately and no partial write completes.
  - A pending `Done` is lost.
- **Latency, counting the acceptance edge as edge 0 and giving the cycle in which `Done` is high:**
  - Load: cycle 2 (RD in cycle 1).
  - Word store: cycle 2 (WR in cycle 1).
  - Byte or half store: cycle 3 (RD in cycle 1, WR in cycle 2).
  - Rejected request: cycle 1.
- **Data visibility:**
  - Store data is committed at the rising edge ending WR.
  - `Load_data` is valid from the first cycle of DONE onward.
- **Throughput:** `Busy` is low only in IDLE, so the next request can be accepted at the edge ending the IDLE cycle that follows DONE. Minimum issue spacing is 3 cycles for a word access, 4 for a sub-word store and 2 for a rejected request.
- **Memory-side assumptions:**
  - The memory captures writes on the same `Clk` rising edge.
  - The read port is combinational, so `Mem_read_data` is stable by the end of RD.

## Test plan
1. **Word store then word load.** Store `0xDEADBEEF` to `0x10`, then load a word from `0x10`.
   - Store: `Mem_write` is high exactly one cycle with `Mem_addr=0x10`.
   - Load: `Done` arrives in cycle 2 and `Load_data=0xDEADBEEF`.
2. **Byte store read-modify-write.** Memory at `0x10` holds `0x11223344`; store byte `0xAA` to `0x12`.
   - Written word is `0x11AA3344`.
   - `Done` arrives in cycle 3 and `Mem_write` is high only in cycle 2.
3. **Sign and zero extension.** Memory at `0x20` holds `0x80F07F01`.
   - Signed byte load from `0x22` → `0xFFFFFFF0`.
   - Unsigned half load from `0x22` → `0x000080F0`.
   - Signed half load from `0x20` → `0x00007F01`.
4. **Misaligned word store.** Store a word to `0x13`.
   - `Done` and `Err` are high in cycle 1.
   - `Mem_write` is never asserted and the memory is unchanged.
5. **Reset during a sub-word store.** Assert `Reset_n=0` while the FSM is in WR.
   - `Mem_write` and `Busy` drop without waiting for a clock edge.
   - All outputs read 0.
   - The target word keeps its old value.
6. **Request while busy.** Pulse `Req` during RD of a load.
   - The pulse is ignored: exactly one `Done` occurs, and `Mem_addr` does not change until the next IDLE acceptance.
